// File: rtl/apb_bus_arbiter_if.sv
// APB master-side bus between apb_bus_arbiter and apb_slave.
// The master drives the command, and the slave returns ready, read data and error.
interface apb_bus_arbiter_if;
  logic        wr_in;
  logic        en;
  logic        en_in;
  logic [2:0]  sel_port;
  logic [11:0] addr_in;
  logic [31:0] data_in;
  logic        ready;
  logic [31:0] readdata;
  logic        PSLVERR;

  modport master (
    output wr_in, en, en_in, sel_port, addr_in, data_in,
    input  ready, readdata, PSLVERR
  );

  modport slave (
    input  wr_in, en, en_in, sel_port, addr_in, data_in,
    output ready, readdata, PSLVERR
  );
endinterface

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter that shares one APB master path between NREQ requesters.
// Define APB_TIMEOUT_EN to force an error completion after TIMEOUT_CYC ACCESS wait cycles.
module apb_bus_arbiter #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*15-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  apb_bus_arbiter_if.master    apb
);

  localparam int unsigned PW = $clog2(NREQ);

  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("apb_bus_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic [PW-1:0]   nxt_ptr;
  logic            found;
  logic            done;
  logic            done_err;
  logic [31:0]     done_rdata;
  int unsigned     idx;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] tcnt;
`endif

  // Search starts at rr_ptr and wraps, so the last owner gets lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (i + 32'(rr_ptr)) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst && state == IDLE && found) gnt[win] = 1'b1;
  end

  assign nxt_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    done       = (state == ACCESS) && apb.ready;
    done_err   = apb.PSLVERR;
    done_rdata = apb.wr_in ? '0 : apb.readdata;
`ifdef APB_TIMEOUT_EN
    if (state == ACCESS && !apb.ready && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      done       = 1'b1;
      done_err   = 1'b1;
      done_rdata = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      apb.wr_in    <= 1'b0;
      apb.en       <= 1'b0;
      apb.en_in    <= 1'b0;
      apb.sel_port <= '0;
      apb.addr_in  <= '0;
      apb.data_in  <= '0;
`ifdef APB_TIMEOUT_EN
      tcnt         <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner                      <= win;
            apb.wr_in                  <= req_wr[win];
            {apb.sel_port, apb.addr_in} <= req_addr[32'(win)*15 +: 15];
            apb.data_in                <= req_wdata[32'(win)*32 +: 32];
            apb.en_in                  <= 1'b1;
            busy                       <= 1'b1;
            state                      <= SETUP;
          end
        end
        SETUP: begin
          apb.en <= 1'b1;
          state  <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tcnt   <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= done_rdata;
            rsp_err          <= done_err;
            rr_ptr           <= nxt_ptr;
            apb.en           <= 1'b0;
            apb.en_in        <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: directed and random transfers checked against a transaction-level model.
module tb_apb_bus_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned TOUT = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_wr;
  logic [NREQ*15-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                busy;

  apb_bus_arbiter_if apb ();

  apb_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .apb(apb)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_ptr = 0;
  logic [31:0] last_rd = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int unsigned j);
    return NREQ'(1) << j;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int unsigned rr_pick(input logic [NREQ-1:0] m, input int unsigned ptr);
    for (int unsigned k = 0; k < NREQ; k++)
      if ((m & onehot((ptr + k) % NREQ)) != '0) return (ptr + k) % NREQ;
    return 0;
  endfunction

  task automatic set_cmd(input int unsigned i, input logic wr, input logic [14:0] a, input logic [31:0] d);
    req_wr[i +: 1]       = wr;
    req_addr[i*15 +: 15] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_gnt"}, 32'(gnt), 0);
    chk({t, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({t, "_rsp_rdata"}, rsp_rdata, 0);
    chk({t, "_rsp_err"}, 32'(rsp_err), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_en"}, 32'(apb.en), 0);
    chk({t, "_en_in"}, 32'(apb.en_in), 0);
    chk({t, "_wr_in"}, 32'(apb.wr_in), 0);
    chk({t, "_sel_port"}, 32'(apb.sel_port), 0);
    chk({t, "_addr_in"}, 32'(apb.addr_in), 0);
    chk({t, "_data_in"}, apb.data_in, 0);
  endtask

  // Entered mid-cycle in an IDLE cycle; returns at the negedge of the completion cycle.
  task automatic do_xfer(input logic [NREQ-1:0] mask, input bit hold, input int unsigned waits,
                         input bit err, input logic [31:0] rdv, input bit stuck,
                         output int unsigned w);
    logic        ew;
    logic [14:0] ea;
    logic [31:0] ed;
    int unsigned n_acc;
    req = mask;
    #1;
    w = 0;
    if (mask == '0) begin
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_busy", 32'(busy), 0);
      @(negedge clk);
      return;
    end
    w = rr_pick(mask, exp_ptr);
    chk("gnt", 32'(gnt), 32'(onehot(w)));
    chk("gnt_busy", 32'(busy), 0);
    ew = req_wr[w +: 1];
    ea = req_addr[w*15 +: 15];
    ed = req_wdata[w*32 +: 32];
    @(posedge clk); #1;
    if (!hold) req = req & ~onehot(w);
    set_cmd(w, 1'($urandom), 15'($urandom), $urandom);
    @(negedge clk);
    chk("setup_en_in", 32'(apb.en_in), 1);
    chk("setup_en", 32'(apb.en), 0);
    chk("setup_gnt", 32'(gnt), 0);
    chk("setup_busy", 32'(busy), 1);
    chk("setup_wr_in", 32'(apb.wr_in), 32'(ew));
    chk("setup_sel_port", 32'(apb.sel_port), 32'(ea[14:12]));
    chk("setup_addr_in", 32'(apb.addr_in), 32'(ea[11:0]));
    chk("setup_data_in", apb.data_in, ed);
    chk("rdata_hold", rsp_rdata, last_rd);
    chk("err_hold", 32'(rsp_err), 32'(last_err));
    n_acc = stuck ? TOUT : waits + 1;
    for (int unsigned k = 0; k < n_acc; k++) begin
      @(posedge clk); #1;
      apb.ready    = !stuck && (k == waits);
      apb.readdata = (!stuck && k == waits) ? rdv : $urandom;
      apb.PSLVERR  = (!stuck && k == waits) ? err : 1'($urandom);
      @(negedge clk);
      chk("acc_en", 32'(apb.en), 1);
      chk("acc_en_in", 32'(apb.en_in), 1);
      chk("acc_gnt", 32'(gnt), 0);
      chk("acc_rsp_valid", 32'(rsp_valid), 0);
      chk("acc_addr_in", 32'(apb.addr_in), 32'(ea[11:0]));
    end
    @(posedge clk); #1;
    apb.ready    = stuck;
    apb.readdata = $urandom;
    apb.PSLVERR  = 1'($urandom);
    last_rd  = (stuck || ew) ? 32'h0 : rdv;
    last_err = stuck ? 1'b1 : err;
    @(negedge clk);
    chk("done_rsp_valid", 32'(rsp_valid), 32'(onehot(w)));
    chk("done_rsp_rdata", rsp_rdata, last_rd);
    chk("done_rsp_err", 32'(rsp_err), 32'(last_err));
    chk("done_en", 32'(apb.en), 0);
    chk("done_en_in", 32'(apb.en_in), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_wr_in", 32'(apb.wr_in), 32'(ew));
    chk("done_sel_port", 32'(apb.sel_port), 32'(ea[14:12]));
    exp_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    int unsigned w;
    rst = 1'b0;
    req = 3'b111;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    apb.ready = 1'b0;
    apb.readdata = '0;
    apb.PSLVERR = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    req = '0;
    @(negedge clk);
    rst = 1'b1;

    set_cmd(0, 1'b1, 15'h2004, 32'hDEADBEEF);
    do_xfer(3'b001, 1'b0, 0, 1'b0, 32'h0, 1'b0, w);
    chk("wr_owner", w, 0);

    set_cmd(1, 1'b0, 15'h5010, 32'h0);
    do_xfer(3'b010, 1'b0, 4, 1'b0, 32'h12345678, 1'b0, w);
    chk("rd_rdata", rsp_rdata, 32'h12345678);

    set_cmd(2, 1'b0, 15'h1020, 32'h0);
    do_xfer(3'b100, 1'b0, 0, 1'b1, 32'hCAFE0001, 1'b0, w);
    chk("slverr_err", 32'(rsp_err), 1);

    for (int unsigned i = 0; i < 6; i++) begin
      do_xfer(3'b111, 1'b1, i % 2, 1'b0, $urandom, 1'b0, w);
      chk("rr_order", w, i % NREQ);
    end

    for (int i = 0; i < 30; i++) begin
      for (int unsigned j = 0; j < NREQ; j++)
        set_cmd(j, 1'($urandom), 15'($urandom), $urandom);
      do_xfer(NREQ'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom, 1'b0, w);
    end

`ifdef APB_TIMEOUT_EN
    set_cmd(0, 1'b0, 15'h3000, 32'h0);
    do_xfer(3'b001, 1'b0, 0, 1'b0, 32'h0, 1'b1, w);
    chk("timeout_owner", w, 0);
`endif

    req = 3'b010;
    #1;
    w = rr_pick(3'b010, exp_ptr);
    chk("mid_gnt", 32'(gnt), 32'(onehot(w)));
    @(posedge clk); #1;
    req = '0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      apb.ready = 1'b0;
      @(negedge clk);
      chk("stuck_busy", 32'(busy), 1);
      chk("stuck_en", 32'(apb.en), 1);
      chk("stuck_rsp_valid", 32'(rsp_valid), 0);
`ifdef APB_TIMEOUT_EN
      if (k == TOUT - 2) break;
`endif
    end
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    req = 3'b101;
    set_cmd(0, 1'b1, 15'h7ABC, 32'h0BADF00D);
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b1;
    exp_ptr = 0;
    last_rd = '0;
    last_err = 1'b0;
    do_xfer(3'b101, 1'b0, 1, 1'b0, $urandom, 1'b0, w);
    chk("rst_first_gnt", w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
